// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for PLL-driven reset sequencing.
// Default window lengths match the gb3 top-level clocking.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABLE     = 3'd1,
        REL_PERIPH = 3'd2,
        RUN        = 3'd3,
        DRAIN      = 3'd4
    } pll_state_e;

    localparam int GB3_LOCK_CYCLES = 1024;
    localparam int GB3_STAGE_GAP   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// Both stages clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged peripheral/core reset release gated on a stable PLL lock.
// Lock loss or a soft request re-asserts both resets.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_CYCLES = GB3_LOCK_CYCLES,
    parameter int STAGE_GAP   = GB3_STAGE_GAP,
    parameter int RELOCK_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                soft_rst_req,
    output logic                periph_rst_n,
    output logic                core_rst_n,
    output logic                sys_ready,
    output logic [RELOCK_W-1:0] relock_count,
    output logic [2:0]          state
);

    localparam int CNT_W =
        $clog2(max_int(LOCK_CYCLES, STAGE_GAP));
    localparam logic [CNT_W-1:0] LOCK_LAST =
        CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'(STAGE_GAP - 1);

    logic             lock_s;
    pll_state_e       state_q;
    pll_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             lost;
    logic             cnt_en;
    logic             periph_d;
    logic             core_d;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            relock_count <= '0;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
            sys_ready    <= 1'b0;
        end else begin
            state_q      <= state_d;
            periph_rst_n <= periph_d;
            core_rst_n   <= core_d;
            sys_ready    <= core_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (cnt_en)
                cnt_q <= cnt_q + 1'b1;
            if (lost && (relock_count != '1))
                relock_count <= relock_count + 1'b1;
        end
    end

    // Lock loss outranks a soft request, which outranks the counter.
    always_comb begin
        state_d = state_q;
        lost    = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s)
                    state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s)
                    state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST)
                    state_d = REL_PERIPH;
            end
            REL_PERIPH: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost    = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost    = 1'b1;
                end else if (soft_rst_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost    = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = REL_PERIPH;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        cnt_en   = 1'b0;
        periph_d = 1'b0;
        core_d   = 1'b0;
        unique case (1'b1)
            (state_q == STABLE),
            (state_q == REL_PERIPH),
            (state_q == DRAIN): cnt_en = 1'b1;
            default:            cnt_en = 1'b0;
        endcase
        unique case (1'b1)
            (state_d == RUN): begin
                periph_d = 1'b1;
                core_d   = 1'b1;
            end
            (state_d == REL_PERIPH): periph_d = 1'b1;
            default:                 periph_d = 1'b0;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer, LOCK_CYCLES=8, STAGE_GAP=4.
// Expected output vectors are queued per edge and checked on the falling edge.
module tb_pll_reset_sequencer;
    import pll_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic       sys_ready;
    logic [7:0] relock_count;
    logic [2:0] state;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int          at;
        logic [13:0] val;
    } exp_t;

    exp_t        eq[$];
    string       tq[$];
    exp_t        ce;
    string       ct;
    logic [13:0] obs_now;

    pll_reset_sequencer #(
        .LOCK_CYCLES (8),
        .STAGE_GAP   (4),
        .RELOCK_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .periph_rst_n (periph_rst_n),
        .core_rst_n   (core_rst_n),
        .sys_ready    (sys_ready),
        .relock_count (relock_count),
        .state        (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    assign obs_now = {periph_rst_n, core_rst_n, sys_ready,
                      state, relock_count};

    function automatic logic [13:0] pk(
        input logic p, input logic c, input logic r,
        input logic [2:0] st, input logic [7:0] n);
        return {p, c, r, st, n};
    endfunction

    function automatic logic [13:0] e_wait(input logic [7:0] n);
        return pk(1'b0, 1'b0, 1'b0, 3'd0, n);
    endfunction
    function automatic logic [13:0] e_stable(input logic [7:0] n);
        return pk(1'b0, 1'b0, 1'b0, 3'd1, n);
    endfunction
    function automatic logic [13:0] e_rel(input logic [7:0] n);
        return pk(1'b1, 1'b0, 1'b0, 3'd2, n);
    endfunction
    function automatic logic [13:0] e_run(input logic [7:0] n);
        return pk(1'b1, 1'b1, 1'b1, 3'd3, n);
    endfunction
    function automatic logic [13:0] e_drain(input logic [7:0] n);
        return pk(1'b0, 1'b0, 1'b0, 3'd4, n);
    endfunction

    task automatic push(input int at, input logic [13:0] v,
                        input string t);
        exp_t e;
        e.at  = at;
        e.val = v;
        eq.push_back(e);
        tq.push_back(t);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string t, input logic [13:0] v);
        compared++;
        assert (obs_now === v) else begin
            mismatched++;
            $error("FAIL %s obs=%h exp=%h", t, obs_now, v);
        end
    endtask

    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].at <= cyc) begin
            ce = eq.pop_front();
            ct = tq.pop_front();
            compared++;
            assert (ce.at == cyc && obs_now === ce.val) else begin
                mismatched++;
                $error("FAIL %s edge=%0d/%0d obs=%h exp=%h",
                       ct, cyc, ce.at, obs_now, ce.val);
            end
        end
    end

    initial begin
        int t;
        int l;
        int g;
        logic [7:0] rc;

        tick(3);
        check_now("reset", e_wait(8'd0));

        rst_n = 1'b1;
        t = cyc;
        push(t + 1, e_wait(8'd0), "pu_idle");
        tick(5);
        pll_locked = 1'b1;
        push(t + 7,  e_wait(8'd0),   "pu_sync");
        push(t + 8,  e_stable(8'd0), "pu_stable");
        push(t + 15, e_stable(8'd0), "pu_window");
        push(t + 16, e_rel(8'd0),    "pu_periph");
        push(t + 19, e_rel(8'd0),    "pu_gap");
        push(t + 20, e_run(8'd0),    "pu_run");
        tick(17);

        l = cyc;
        pll_locked = 1'b0;
        push(l + 2, e_run(8'd0),  "loss_lat");
        push(l + 3, e_wait(8'd1), "loss_wait");
        tick(3);
        pll_locked = 1'b1;
        push(l + 5,  e_wait(8'd1),   "relock_sync");
        push(l + 6,  e_stable(8'd1), "relock_stable");
        push(l + 14, e_rel(8'd1),    "relock_periph");
        push(l + 18, e_run(8'd1),    "relock_run");
        tick(16);

        l = cyc;
        soft_rst_req = 1'b1;
        push(l + 1, e_drain(8'd1), "soft_drain");
        push(l + 4, e_drain(8'd1), "soft_hold");
        push(l + 5, e_rel(8'd1),   "soft_periph");
        push(l + 8, e_rel(8'd1),   "soft_gap");
        push(l + 9, e_run(8'd1),   "soft_run");
        tick(1);
        soft_rst_req = 1'b0;
        tick(9);

        l = cyc;
        pll_locked = 1'b0;
        push(l + 3, e_wait(8'd2), "both_wait");
        push(l + 4, e_wait(8'd2), "both_nodrain");
        tick(2);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        pll_locked = 1'b1;
        push(l + 14, e_rel(8'd2), "both_periph");
        tick(12);

        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", e_wait(8'd0));
        pll_locked = 1'b0;
        tick(2);
        check_now("async_hold", e_wait(8'd0));
        rst_n = 1'b1;

        tick(2);
        g = cyc;
        pll_locked = 1'b1;
        push(g + 3,  e_stable(8'd0), "gl_stable");
        push(g + 5,  e_stable(8'd0), "soft_ignored");
        push(g + 8,  e_wait(8'd0),   "gl_wait");
        push(g + 9,  e_stable(8'd0), "gl_restart");
        push(g + 16, e_stable(8'd0), "gl_window");
        push(g + 17, e_rel(8'd0),    "gl_periph");
        push(g + 21, e_run(8'd0),    "gl_run");
        tick(4);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(16);

        rc = 8'd0;
        for (int i = 0; i < 300; i++) begin
            l = cyc;
            pll_locked = 1'b0;
            rc = (rc == 8'hFF) ? rc : rc + 8'd1;
            push(l + 3, e_wait(rc), "sat_loss");
            tick(3);
            pll_locked = 1'b1;
            push(l + 14, e_rel(rc), "sat_rel");
            tick(11);
        end
        l = cyc;
        push(l + 4, e_run(8'hFF), "sat_run");
        tick(6);

        compared++;
        assert (eq.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_drain obs=%0d exp=0", eq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
